y86_fetch_stage: RTL
====================

Name: y86_fetch_stage

Overview:
- Pipeline fetch stage of the Y86-64 core.
- Selects the fetch PC from the predicted PC, a mispredicted-branch redirect or a ret redirect, then splits the 10-byte instruction window into fields.
- Drives the f_* bundle consumed by the decode pipeline register, and holds the F_predPC register.
- Sticky halt tracking stops fetch after a non-AOK status unless a redirect squashes it.

Parameters:
- RESET_PC, 64'h0, value loaded into F_predPC on reset.

Ports:
- clk  in  1  clock, posedge.
- rst_n  in  1  synchronous active-low reset.
- F_stall  in  1  hold F_predPC and the halt latch.
- M_icode  in  4  icode in memory stage.
- M_Cnd  in  1  branch condition in memory stage.
- M_valA  in  64  fall-through PC of the jXX in M.
- W_icode  in  4  icode in writeback stage.
- W_valM  in  64  return address of the ret in W.
- imem_addr  out  64  selected fetch PC.
- imem_bytes  in  80  mem[pc+k] on bits [8k+7:8k], k=0..9.
- imem_error  in  1  fetch address out of range.
- f_stat  out  2  0 AOK, 1 HLT, 2 ADR, 3 INS.
- f_icode, f_ifun, f_rA, f_rB  out  4 each  instruction fields.
- f_valC, f_valP  out  64 each  constant, next sequential PC.
- F_predPC  out  64  registered predicted PC.
- f_halted  out  1  sticky halt flag.

Behaviour:
- Reset (rst_n=0 at posedge, overrides F_stall): F_predPC<=RESET_PC, f_halted<=0.
- PC select, highest priority first:
  - M_icode==7 && !M_Cnd: M_valA.
  - W_icode==9: W_valM.
  - Otherwise F_predPC.
  - redirect = either of the first two conditions.
- Field extraction:
  - icode=byte0[7:4], ifun=byte0[3:0].
  - need_regids for icode 2,3,4,5,6,A,B; then rA=byte1[7:4], rB=byte1[3:0], else both 4'hF.
  - need_valC for icode 3,4,5,7,8.
  - valC is little-endian 64-bit, from bytes 2..9 if need_regids, else bytes 1..8. valC=0 if not needed.
  - valP = pc + 1 + need_regids + 8*need_valC, 64-bit, wrap-around modulo 2^64.
- Validity:
  - Valid icodes are 0..B.
  - ifun must be 0 for 0,1,3,4,5,8,9,A,B.
  - ifun must be <=6 for 2 and 7, and <=3 for 6.
- Status, priority order:
  - imem_error gives ADR.
  - Else invalid gives INS.
  - Else icode==0 gives HLT.
  - Else AOK.
- On ADR or INS: f_icode=1 (nop), f_ifun=0, rA=rB=F, valC=0; valP still computed.
- Prediction: icode 7 or 8 gives predPC=valC, else valP.
- Clocked update (rst_n=1): if !F_stall, F_predPC<=predPC.
- Halt latch:
  - If !F_stall && f_stat!=AOK && !f_halted, then f_halted<=1 and the status is latched.
  - If redirect, f_halted<=0 (the halt was on a squashed path). Redirect clears the latch even when F_stall=1.
- While f_halted=1 and no redirect:
  - f_stat = latched status, f_icode=1, other fields neutral as for ADR/INS.
  - F_predPC is not updated.
- A redirect during halted fetches normally that cycle.
- All f_* and imem_addr are combinational from registers and inputs; zero-cycle latency from imem_bytes.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds output ports:
  - fetch_count (32 bits): increments when !F_stall && !f_halted && f_stat==AOK.
  - stall_count (32 bits): increments when F_stall=1.
  - Both reset to 0 on rst_n=0 and wrap at 2^32.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0x100, fetch irmovq 0x30 F2 + valC 0x1122334455667788 -> rB=2, rA=F, valC=0x1122334455667788, valP=0x10A, F_predPC=0x10A after the clock.
- jXX 0x70 with dest 0x200 at PC 0x40, then next cycle M_icode=7, M_Cnd=0, M_valA=0x49 with W_icode=9 also set -> imem_addr=0x49 (mispredict wins over ret).
- Byte0=0xC0 -> f_stat=3, f_icode=1. Byte0=0x67 -> INS. imem_error=1 with a valid opcode -> f_stat=2.
- halt fetched with F_stall=0 -> f_halted=1, F_predPC frozen, f_stat=1 for 3 cycles; then M mispredict -> f_halted=0, fetch at M_valA.
- F_stall=1 for 2 cycles -> F_predPC unchanged, halt latch unchanged. Reset asserted while F_stall=1 -> F_predPC=RESET_PC.
- F_predPC=0xFFFFFFFFFFFFFFFE with nop -> valP=0xFFFFFFFFFFFFFFFF. With FETCH_PERF_CNT_EN, 5 AOK fetches and 2 stalls -> fetch_count=5, stall_count=2.

Source files
------------

// File: rtl/y86_fetch_stage_if.sv
// Instruction-memory port of the Y86-64 fetch stage.
// Fetch drives the address; memory returns a 10-byte window and an error flag.
interface y86_fetch_stage_if;
   logic [63:0] imem_addr;
   logic [79:0] imem_bytes;
   logic        imem_error;

   modport master (
      output imem_addr,
      input  imem_bytes,
      input  imem_error
   );

   modport slave (
      input  imem_addr,
      output imem_bytes,
      output imem_error
   );
endinterface

// File: rtl/y86_fetch_stage.sv
// Y86-64 fetch stage: PC select, field split, prediction, sticky halt.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module y86_fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        F_stall,
   input  logic [3:0]  M_icode,
   input  logic        M_Cnd,
   input  logic [63:0] M_valA,
   input  logic [3:0]  W_icode,
   input  logic [63:0] W_valM,
   y86_fetch_stage_if.master imem,
   output logic [1:0]  f_stat,
   output logic [3:0]  f_icode,
   output logic [3:0]  f_ifun,
   output logic [3:0]  f_rA,
   output logic [3:0]  f_rB,
   output logic [63:0] f_valC,
   output logic [63:0] f_valP,
   output logic [63:0] F_predPC,
   output logic        f_halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   localparam logic [1:0] S_AOK = 2'd0;
   localparam logic [1:0] S_HLT = 2'd1;
   localparam logic [1:0] S_ADR = 2'd2;
   localparam logic [1:0] S_INS = 2'd3;

   logic        mispredict;
   logic        ret_rd;
   logic        redirect;
   logic        halt_hold;
   logic        neutral;
   logic [63:0] pc;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic        need_regids;
   logic        need_valc;
   logic        valid;
   logic [63:0] valc;
   logic [1:0]  raw_stat;
   logic [1:0]  halt_stat;
   logic [63:0] pred_pc;

   assign mispredict = (M_icode == 4'h7) && !M_Cnd;
   assign ret_rd     = (W_icode == 4'h9);
   assign redirect   = mispredict || ret_rd;
   assign halt_hold  = f_halted && !redirect;

   // Fetch PC: mispredicted branch beats ret, both beat prediction.
   always_comb begin
      pc = F_predPC;
      if (mispredict)  pc = M_valA;
      else if (ret_rd) pc = W_valM;
   end

   assign imem.imem_addr = pc;
   assign icode = imem.imem_bytes[7:4];
   assign ifun  = imem.imem_bytes[3:0];

   // Per-opcode decode of length fields and legality.
   always_comb begin
      need_regids = 1'b0;
      need_valc   = 1'b0;
      valid       = 1'b0;
      case (icode)
         4'h0, 4'h1: valid = (ifun == 4'h0);
         4'h2: begin
            need_regids = 1'b1;
            valid       = (ifun <= 4'h6);
         end
         4'h3, 4'h4, 4'h5: begin
            need_regids = 1'b1;
            need_valc   = 1'b1;
            valid       = (ifun == 4'h0);
         end
         4'h6: begin
            need_regids = 1'b1;
            valid       = (ifun <= 4'h3);
         end
         4'h7: begin
            need_valc = 1'b1;
            valid     = (ifun <= 4'h6);
         end
         4'h8: begin
            need_valc = 1'b1;
            valid     = (ifun == 4'h0);
         end
         4'h9: valid = (ifun == 4'h0);
         4'hA, 4'hB: begin
            need_regids = 1'b1;
            valid       = (ifun == 4'h0);
         end
         default: valid = 1'b0;
      endcase
   end

   // Constant sits after the register byte when one is present.
   always_comb begin
      valc = 64'h0;
      if (need_valc)
         valc = need_regids ? imem.imem_bytes[79:16]
                            : imem.imem_bytes[71:8];
   end

   assign f_valP = pc + 64'd1 + {63'd0, need_regids}
                 + (need_valc ? 64'd8 : 64'd0);

   // Status of the bytes at pc, ignoring the halt latch.
   always_comb begin
      raw_stat = S_AOK;
      if (imem.imem_error)    raw_stat = S_ADR;
      else if (!valid)        raw_stat = S_INS;
      else if (icode == 4'h0) raw_stat = S_HLT;
   end

   assign neutral = halt_hold || (raw_stat == S_ADR)
                 || (raw_stat == S_INS);

   // Bad or halted fetches present a nop with neutral fields.
   always_comb begin
      f_stat  = halt_hold ? halt_stat : raw_stat;
      f_icode = icode;
      f_ifun  = ifun;
      f_rA    = 4'hF;
      f_rB    = 4'hF;
      f_valC  = valc;
      if (need_regids) begin
         f_rA = imem.imem_bytes[15:12];
         f_rB = imem.imem_bytes[11:8];
      end
      if (neutral) begin
         f_icode = 4'h1;
         f_ifun  = 4'h0;
         f_rA    = 4'hF;
         f_rB    = 4'hF;
         f_valC  = 64'h0;
      end
   end

   assign pred_pc = ((f_icode == 4'h7) || (f_icode == 4'h8))
                  ? f_valC : f_valP;

   // Predicted PC register and sticky halt latch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         F_predPC  <= RESET_PC;
         f_halted  <= 1'b0;
         halt_stat <= S_AOK;
      end else begin
         if (!F_stall && !halt_hold)
            F_predPC <= pred_pc;
         if (redirect) begin
            f_halted <= 1'b0;
         end else if (!F_stall && (f_stat != S_AOK) && !f_halted) begin
            f_halted  <= 1'b1;
            halt_stat <= f_stat;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Good-fetch and stall-cycle counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count <= 32'd0;
         stall_count <= 32'd0;
      end else begin
         if (!F_stall && !f_halted && (f_stat == S_AOK))
            fetch_count <= fetch_count + 32'd1;
         if (F_stall)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule
